// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// PC increment and the bubble word presented when no instruction is held.
package if_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        READY = 1'b1
    } if_state_t;

    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC / next-state selection for the fetch stage.
// Priority, highest first: reset, branch redirect, hold, memory ack.
// Purely combinational; the flops live in if_fetch_unit.
module if_next_pc
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic      rst,
    input  logic      branch_taken,
    input  logic [31:0] branch_target,
    input  logic      hold,
    input  logic      ack,
    input  logic [31:0] pc_cur,
    input  if_state_t state_cur,
    output logic [31:0] pc_next,
    output if_state_t state_next,
    output logic      instr_load
);

    // Resolve the next PC, next state and whether the acked word is captured.
    always_comb begin
        pc_next    = pc_cur;
        state_next = state_cur;
        instr_load = 1'b0;
        if (!rst) begin
            pc_next    = RESET_PC;
            state_next = FETCH;
        end else if (branch_taken) begin
            // A word acked in the redirect cycle is dropped.
            pc_next    = branch_target;
            state_next = FETCH;
        end else begin
            case (state_cur)
                FETCH: begin
                    // An ack in FETCH is taken even under hold; the word then waits in READY.
                    if (ack) begin
                        instr_load = 1'b1;
                        state_next = READY;
                    end else begin
                        state_next = FETCH;
                    end
                end
                READY: begin
                    if (hold) begin
                        state_next = READY;
                    end else begin
                        // The presented word is consumed; move on to the following address.
                        pc_next = pc_cur + PC_STEP;
                        if (ack) begin
                            instr_load = 1'b1;
                            state_next = READY;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register. Holds the PC and the
// last fetched word; presents a zero bubble whenever no word is available.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        loadForwardStall,
    input  logic        superStall,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC
);

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    if_state_t   state_r;

    logic        hold_s;
    logic [31:0] pc_plus_s;
    logic        req_raw_s;
    logic        ack_s;
    logic [31:0] pc_next_s;
    if_state_t   state_next_s;
    logic        instr_load_s;

    assign hold_s    = stall | loadForwardStall | superStall;
    assign pc_plus_s = pc_r + PC_STEP;
    // An ack only counts against a live request.
    assign ack_s     = imem_ack & imem_req;

    // Memory request and IF/ID-facing outputs from registered state, hold and reset.
    always_comb begin
        req_raw_s   = 1'b1;
        imem_addr   = pc_r;
        Instruction = NOP_WORD;
        PC          = NOP_WORD;
        if (state_r == READY) begin
            req_raw_s   = ~hold_s;
            imem_addr   = pc_plus_s;
            Instruction = instr_r;
            PC          = pc_plus_s;
        end else begin
            req_raw_s   = 1'b1;
            imem_addr   = pc_r;
            Instruction = NOP_WORD;
            PC          = NOP_WORD;
        end
        imem_req = rst & req_raw_s;
    end

    if_next_pc #(
        .RESET_PC (RESET_PC)
    ) u_next_pc (
        .rst           (rst),
        .branch_taken  (Branch_taken),
        .branch_target (Branch_target),
        .hold          (hold_s),
        .ack           (ack_s),
        .pc_cur        (pc_r),
        .state_cur     (state_r),
        .pc_next       (pc_next_s),
        .state_next    (state_next_s),
        .instr_load    (instr_load_s)
    );

    // State, PC and instruction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r    <= RESET_PC;
            instr_r <= NOP_WORD;
            state_r <= FETCH;
        end else begin
            pc_r    <= pc_next_s;
            state_r <= state_next_s;
            if (instr_load_s) begin
                instr_r <= imem_rdata;
            end else begin
                instr_r <= instr_r;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit. The stimulus process drives one cycle
// at a time and pushes the expected outputs for that cycle, computed from a
// word-level model (which address is presented / being fetched). A monitor
// process pops and compares mid-cycle.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        loadForwardStall;
    logic        superStall;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;

    bit scramble = 1'b0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Word-level model: m_a is the address of the presented word when m_have,
    // otherwise the address currently being fetched.
    bit          m_have = 1'b0;
    logic [31:0] m_a    = RST_PC;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a, input bit s);
        logic [31:0] w;
        if (s) begin
            w = {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
        end else begin
            w = a;
        end
        return w;
    endfunction

    // Instruction memory: data is a fixed function of the requested address.
    assign imem_rdata = mem_fn(imem_addr, scramble);

    if_fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .loadForwardStall (loadForwardStall),
        .superStall       (superStall),
        .Branch_taken     (Branch_taken),
        .Branch_target    (Branch_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .Instruction      (Instruction),
        .PC               (PC)
    );

    task automatic step(input bit r, input bit s, input bit l, input bit ss,
                        input bit br, input logic [31:0] tgt, input bit ack);
        exp_t e;
        bit   hold;
        bit   acked;
        @(negedge clk);
        rst              = r;
        stall            = s;
        loadForwardStall = l;
        superStall       = ss;
        Branch_taken     = br;
        Branch_target    = tgt;
        imem_ack         = ack;
        hold    = s | l | ss;
        e.req   = r && (!m_have || !hold);
        e.addr  = m_have ? m_a + 32'd4 : m_a;
        e.instr = m_have ? mem_fn(m_a, scramble) : 32'h0;
        e.pc    = m_have ? m_a + 32'd4 : 32'h0;
        exp_q.push_back(e);
        acked = e.req && ack;
        if (!r) begin
            m_a    = RST_PC;
            m_have = 1'b0;
        end else if (br) begin
            m_a    = tgt;
            m_have = 1'b0;
        end else if (m_have && hold) begin
            m_have = 1'b1;
        end else if (m_have) begin
            m_a    = m_a + 32'd4;
            m_have = acked;
        end else begin
            m_have = acked;
        end
    endtask

    // Monitor: compare DUT outputs against the expected record of this cycle.
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (Instruction !== mon_e.instr) begin
                bad++;
                $display("FAIL instr t=%0t got=%h exp=%h", $time, Instruction, mon_e.instr);
            end
            total++;
            if (PC !== mon_e.pc) begin
                bad++;
                $display("FAIL pc t=%0t got=%h exp=%h", $time, PC, mon_e.pc);
            end
            total++;
            if (imem_req !== mon_e.req) begin
                bad++;
                $display("FAIL req t=%0t got=%b exp=%b", $time, imem_req, mon_e.req);
            end
            if (mon_e.req) begin
                total++;
                if (imem_addr !== mon_e.addr) begin
                    bad++;
                    $display("FAIL addr t=%0t got=%h exp=%h", $time, imem_addr, mon_e.addr);
                end
            end
        end
    end

    initial begin
        logic [31:0] rnd;
        logic [31:0] tgt;
        rst = 1'b0; stall = 1'b0; loadForwardStall = 1'b0; superStall = 1'b0;
        Branch_taken = 1'b0; Branch_target = 32'h0; imem_ack = 1'b0;

        // reset held: request must stay low even with ack asserted
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // zero-wait stream, data = address
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // ack on every third cycle
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, (i % 3) == 2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // stall for 4 cycles while a word is shown
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // branch together with an ack
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // branch under superStall, then an ack while still held
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // mid-stream reset, then restart with scrambled memory contents
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        scramble = 1'b1;
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // wrap through 32'hFFFF_FFFC to 0
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom();
            tgt = {rnd[31:2], 2'b00};
            if ($urandom_range(0, 3) == 0) begin
                tgt = 32'hFFFF_FFF8;
            end
            step($urandom_range(0, 63) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 15) == 0,
                 tgt,
                 $urandom_range(0, 3) != 0);
        end

        repeat (2) @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
